hazard_unit: RTL
================

# hazard_unit

Parametrised load-use / control hazard controller for the pipelined RV32I core, sitting between the ID and EX stages and driving the pipeline-register enables and the PC write strobe. It stalls for a configurable number of bubbles after a load whose destination is read by the instruction in ID. It never stalls on x0, and it flushes IF/ID and ID/EX on a taken branch or jump resolved in EX. A global freeze applies while the data memory is busy. A saturating counter records load-use stall cycles.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- LOAD_USE_STALLS, 1, bubbles per load-use hazard (legal 1..7): 1 with MEM->EX forwarding, 2 without
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  instruction in ID actually reads rs1 / rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes rd
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle
- dmem_busy  in  1  data memory has not completed the access in MEM
- stats_clear  in  1  synchronous clear of stall_cycles
- pc_write  out  1  PC may update
- if_id_enable  out  1  IF/ID register may load
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zeroed)
- pipe_enable  out  1  ID/EX, EX/MEM and MEM/WB may load
- stall_cycles  out  CNT_W  count of load-use stall cycles, saturating

## Operation
- Hazard: `ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- FSM states (hz_state_t):
  - HZ_RUN
  - HZ_LU_STALL, with down-counter `rem` of width 3
- Priority, highest first, evaluated every cycle:
  1. **dmem_busy = 1**: freeze.
     - pc_write=0, if_id_enable=0, pipe_enable=0, bubble=0, flush=0.
     - State, rem and stall_cycles hold.
     - Hazard detection is ignored; it is re-evaluated once the freeze lifts because EX is frozen.
  2. **ex_branch_taken = 1**: flush.
     - pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_enable=1, pipe_enable=1.
     - Next state HZ_RUN, rem=0; an in-progress load-use stall is abandoned.
  3. **Stall** (HZ_RUN with hazard true, or HZ_LU_STALL):
     - pc_write=0, if_id_enable=0, id_ex_bubble=1, pipe_enable=1.
     - stall_cycles increments.
     - In HZ_RUN with LOAD_USE_STALLS>1: go to HZ_LU_STALL with rem=LOAD_USE_STALLS-1.
     - In HZ_LU_STALL: rem decrements; when rem==1, go to HZ_RUN.
  4. **Otherwise**: pc_write=1, if_id_enable=1, pipe_enable=1, bubble=0, flush=0.
- Total bubbles per hazard equal LOAD_USE_STALLS exactly.
- HZ_LU_STALL does not re-check the hazard: the load has already left EX.
- stall_cycles:
  - Saturates at 2^CNT_W-1.
  - stats_clear has priority over increment; the counter reads 0 the next cycle.

## Timing
- All control outputs are combinational from inputs and state within the same cycle; zero latency from hazard detection to stall.
- State, rem and stall_cycles are registered on the rising edge of clk.
- While rst_n=0: state=HZ_RUN, rem=0, stall_cycles=0. Outputs take the "otherwise" values regardless of inputs: pc_write=1, if_id_enable=1, pipe_enable=1, if_id_flush=0, id_ex_bubble=0.
- Reset asserted mid-stall aborts the stall immediately; no residual bubbles follow reset release.
- A branch and a hazard cannot legally coincide (EX holds a single instruction); if both are asserted, the branch wins.
- dmem_busy in HZ_LU_STALL extends wall-clock time but not the bubble count.

## Structure
- hazard_pkg holds:
  - hz_state_t enum {HZ_RUN, HZ_LU_STALL}
  - localparam REM_W = 3
  - function hz_is_x0
- Sub-module hazard_match (combinational): one ex_rd vs two rs with use bits and x0 exclusion, producing the hazard bit. It is reused later for a MEM-stage producer check.
- Top: FSM, rem counter, statistics counter, output decode.

## Test plan
- LOAD_USE_STALLS=1:
  - lw x5 in EX, ID reads x5 via rs2 -> one cycle with pc_write=0, id_ex_bubble=1; next cycle all enables high; stall_cycles=1.
  - lw x0 in EX, ID reads x0 -> no stall.
  - lw x5 in EX, ID reads x5 but id_uses_rs1=0 -> no stall.
- LOAD_USE_STALLS=3: hazard on x7 -> exactly 3 consecutive bubble cycles, state returns to HZ_RUN, stall_cycles=3.
- LOAD_USE_STALLS=3: dmem_busy=1 for 4 cycles during the second bubble -> freeze with all enables 0; still 3 bubbles total; stall_cycles=3.
- LOAD_USE_STALLS=2: ex_branch_taken=1 in the first HZ_LU_STALL cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; HZ_RUN next cycle; no further bubble.
- CNT_W=4: drive 17 stall cycles -> stall_cycles holds 15.
- stats_clear during a stall -> stall_cycles=0 the next cycle.
- rst_n pulled low mid HZ_LU_STALL -> outputs inactive immediately; HZ_RUN after release.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the ID/EX hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_LU_STALL = 1'b1
    } hz_state_t;

    localparam int REM_W = 3;

    function automatic logic hz_is_x0(input logic [31:0] reg_idx);
        return reg_idx == 32'd0;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of ID/EX hazard inputs and pipeline-control outputs.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic                  ex_reg_write;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  dmem_busy;
    logic                  stats_clear;
    logic                  pc_write;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  pipe_enable;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
               dmem_busy, stats_clear,
        input  pc_write, if_id_enable, if_id_flush, id_ex_bubble,
               pipe_enable, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_mem_read, ex_reg_write, ex_rd, ex_branch_taken,
               dmem_busy, stats_clear,
        output pc_write, if_id_enable, if_id_flush, id_ex_bubble,
               pipe_enable, stall_cycles
    );
endinterface

// File: rtl/hazard_unit_match.sv
// Producer-vs-consumer register match: one destination against two sources,
// never matching x0. Shared by the EX-stage and MEM-stage producer checks.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic                  producer_valid,
    input  logic [REG_ADDR_W-1:0] producer_rd,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = uses_rs1 && (rs1 == producer_rd);
    assign rs2_hit = uses_rs2 && (rs2 == producer_rd);
    assign hazard  = producer_valid && !hz_is_x0(32'(producer_rd)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / control hazard controller: drives PC and pipeline-register
// enables, inserts load-use bubbles, flushes on redirects, freezes on dmem_busy.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    hazard_unit_if.slave hz
);

    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_USE_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    hz_state_t        state;
    logic [REM_W-1:0] rem;
    logic [CNT_W-1:0] stall_cnt;
    logic             hazard;
    logic             stall_now;
    logic             stall_step;

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_ex_match (
        .rs1            (hz.id_rs1),
        .rs2            (hz.id_rs2),
        .uses_rs1       (hz.id_uses_rs1),
        .uses_rs2       (hz.id_uses_rs2),
        .producer_valid (hz.ex_mem_read && hz.ex_reg_write),
        .producer_rd    (hz.ex_rd),
        .hazard         (hazard)
    );

    // Once in HZ_LU_STALL the load has left EX, so the hazard is not re-checked.
    assign stall_now  = (state == HZ_LU_STALL) || hazard;
    assign stall_step = !hz.dmem_busy && !hz.ex_branch_taken && stall_now;

    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_enable = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.pipe_enable  = 1'b1;
        if (rst_n) begin
            if (hz.dmem_busy) begin
                hz.pc_write     = 1'b0;
                hz.if_id_enable = 1'b0;
                hz.pipe_enable  = 1'b0;
            end else if (hz.ex_branch_taken) begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end else if (stall_now) begin
                hz.pc_write     = 1'b0;
                hz.if_id_enable = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
        end
    end

    // A freeze holds state and rem, so the bubble count is unaffected by dmem_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
            rem   <= '0;
        end else if (!hz.dmem_busy) begin
            if (hz.ex_branch_taken) begin
                state <= HZ_RUN;
                rem   <= '0;
            end else if (state == HZ_LU_STALL) begin
                rem <= rem - 1'b1;
                if (rem == REM_W'(1)) begin
                    state <= HZ_RUN;
                end
            end else if (hazard && (LOAD_USE_STALLS > 1)) begin
                state <= HZ_LU_STALL;
                rem   <= REM_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hz.stats_clear) begin
            stall_cnt <= '0;
        end else if (stall_step && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.stall_cycles = stall_cnt;

endmodule
